// File: rtl/corr_result_sequencer.sv
// Harvests finished correlation results from NCORR correlator blocks over the shared register bus
// and queues {chan, cnt, corr64} records for the tracking-loop logic.
module corr_result_sequencer #(
  parameter int unsigned NCORR      = 32,
  parameter logic [31:0] BASE       = 32'hFE000780,
  parameter logic [31:0] STRIDE     = 32'h00000010,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCORR-1:0] seen,
  input  logic             host_busy,
  output logic [31:0]      addr,
  output logic             read,
  input  logic [31:0]      Rdata,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [4:0]       res_chan,
  output logic [31:0]      res_cnt,
  output logic [63:0]      res_corr,
  output logic [NCORR-1:0] overrun
);

  localparam int unsigned AW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CW   = AW + 1;
  localparam int unsigned RecW = 5 + 32 + 64;
  localparam logic [CW-1:0] FifoDepthC = FIFO_DEPTH[CW-1:0];

  typedef enum logic [2:0] {StIdle, StRdCnt, StRdLow, StRdHigh, StRdStat, StPush} state_e;

  state_e           state_q;
  logic [NCORR-1:0] seen_q, pending_q, pending_d, overrun_q, overrun_d, rise, clr_mask, rot;
  logic [4:0]       chan_q, rr_ptr_q, grant_chan;
  logic [31:0]      cnt_q, low_q, high_q, chan_base;
  logic [5:0]       grant_off, gsum;
  logic             grant_found, fifo_full, push, pop;
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    fifo_cnt_q;
  logic [RecW-1:0]  mem_q [FIFO_DEPTH];
  logic [RecW-1:0]  head;

  assign rise      = seen & ~seen_q;
  assign push      = (state_q == StPush);
  assign pop       = res_valid & res_ready;
  assign fifo_full = (fifo_cnt_q == FifoDepthC);
  assign chan_base = BASE + 32'(chan_q) * STRIDE;

  // A rise during the PUSH that retires this channel is a new event, not an overrun.
  always_comb begin
    for (int i = 0; i < NCORR; i++) begin
      clr_mask[i] = push && (chan_q == 5'(i));
    end
    pending_d = (pending_q & ~clr_mask) | rise;
    overrun_d = overrun_q | (rise & pending_q & ~clr_mask);
  end

  // Rotate pending so bit 0 is rr_ptr; the lowest set bit is the round-robin winner.
  always_comb begin
    rot         = NCORR'({pending_q, pending_q} >> rr_ptr_q);
    grant_found = |rot;
    grant_off   = '0;
    for (int i = NCORR - 1; i >= 0; i--) begin
      if (rot[i]) grant_off = 6'(i);
    end
    gsum = {1'b0, rr_ptr_q} + grant_off;
    if (gsum >= 6'(NCORR)) gsum = gsum - 6'(NCORR);
    grant_chan = gsum[4:0];
  end

  always_comb begin
    read = 1'b0;
    addr = '0;
    if (!host_busy) begin
      unique case (state_q)
        StRdCnt:  begin read = 1'b1; addr = chan_base;           end
        StRdLow:  begin read = 1'b1; addr = chan_base + 32'h4;   end
        StRdHigh: begin read = 1'b1; addr = chan_base + 32'h8;   end
        StRdStat: begin read = 1'b1; addr = chan_base + 32'hC;   end
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      seen_q     <= '0;
      pending_q  <= '0;
      overrun_q  <= '0;
      rr_ptr_q   <= '0;
      chan_q     <= '0;
      cnt_q      <= '0;
      low_q      <= '0;
      high_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      seen_q    <= seen;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push && !pop) fifo_cnt_q <= fifo_cnt_q + CW'(1);
      else if (!push && pop) fifo_cnt_q <= fifo_cnt_q - CW'(1);
      unique case (state_q)
        StIdle: begin
          // At most one record is ever in flight, so a non-full FIFO guarantees its slot.
          if (grant_found && !fifo_full) begin
            chan_q  <= grant_chan;
            state_q <= StRdCnt;
          end
        end
        StRdCnt: if (!host_busy) begin
          cnt_q   <= Rdata;
          state_q <= StRdLow;
        end
        StRdLow: if (!host_busy) begin
          low_q   <= Rdata;
          state_q <= StRdHigh;
        end
        StRdHigh: if (!host_busy) begin
          high_q  <= Rdata;
          state_q <= StRdStat;
        end
        StRdStat: if (!host_busy) state_q <= StPush;
        StPush: begin
          wr_ptr_q <= wr_ptr_q + AW'(1);
          rr_ptr_q <= (chan_q == 5'(NCORR - 1)) ? 5'd0 : chan_q + 5'd1;
          state_q  <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) mem_q[wr_ptr_q] <= {chan_q, cnt_q, high_q, low_q};
  end

  assign head      = mem_q[rd_ptr_q];
  assign res_valid = (fifo_cnt_q != '0);
  assign res_chan  = head[RecW-1 -: 5];
  assign res_cnt   = head[95:64];
  assign res_corr  = head[63:0];
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_corr_result_sequencer.sv
// Bench for corr_result_sequencer: directed scenarios plus randomized harvest rounds checked
// against a correlator-slave model and a round-robin record-order scoreboard.
module tb_corr_result_sequencer;

  localparam int unsigned NCORR      = 32;
  localparam logic [31:0] BASE       = 32'hFE000780;
  localparam logic [31:0] STRIDE     = 32'h00000010;
  localparam int unsigned FIFO_DEPTH = 4;

  typedef struct packed {
    logic [4:0]  chan;
    logic [31:0] cnt;
    logic [63:0] corr;
  } rec_t;

  logic             clk = 1'b0;
  logic             rst, host_busy, read, res_valid, res_ready;
  logic [NCORR-1:0] seen, overrun;
  logic [31:0]      addr, Rdata, res_cnt;
  logic [4:0]       res_chan;
  logic [63:0]      res_corr;

  logic [31:0] cnt_mem [NCORR];
  logic [31:0] low_mem [NCORR];
  logic [31:0] high_mem [NCORR];
  logic [31:0] b_off, s_off, mask;
  rec_t        exp_q [$];
  rec_t        r;
  logic        st_hit;
  logic [4:0]  st_ch;
  int          n_checks = 0;
  int          n_fail = 0;
  int          rr_m, last, budget;

  corr_result_sequencer #(
    .NCORR(NCORR), .BASE(BASE), .STRIDE(STRIDE), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .seen(seen), .host_busy(host_busy), .addr(addr), .read(read),
    .Rdata(Rdata), .res_valid(res_valid), .res_ready(res_ready), .res_chan(res_chan),
    .res_cnt(res_cnt), .res_corr(res_corr), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Correlator register file: Cnt/Low/High/Status per 16-byte group.
  always_comb begin
    b_off = addr - BASE;
    Rdata = 32'hBAD0_BAD0;
    if (read) begin
      case (b_off[3:0])
        4'h0:    Rdata = cnt_mem[b_off[8:4]];
        4'h4:    Rdata = low_mem[b_off[8:4]];
        4'h8:    Rdata = high_mem[b_off[8:4]];
        default: Rdata = 32'h0000_0001;
      endcase
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Mid-cycle: bus sanity, record scoreboard, slave Status-read side effect; then next edge.
  task automatic tick();
    #4;
    st_hit = 1'b0;
    st_ch  = '0;
    if (read) begin
      s_off = addr - BASE;
      check("bus_read_while_host_busy", 128'(host_busy), 128'(0));
      check("bus_addr_in_range", 128'({s_off[31:9], s_off[1:0]}), 128'(0));
      st_hit = (s_off[3:0] == 4'hC);
      st_ch  = s_off[8:4];
    end
    if (res_valid && res_ready) begin
      check("record_expected", 128'(exp_q.size() != 0), 128'(1));
      if (exp_q.size() != 0) begin
        r = exp_q.pop_front();
        check("rec_chan", 128'(res_chan), 128'(r.chan));
        check("rec_cnt", 128'(res_cnt), 128'(r.cnt));
        check("rec_corr", 128'(res_corr), 128'(r.corr));
      end
    end
    @(posedge clk);
    #1;
    if (st_hit) seen[st_ch] = 1'b0;
  endtask

  task automatic set_data(input int ch);
    cnt_mem[ch]  = $urandom;
    low_mem[ch]  = $urandom;
    high_mem[ch] = $urandom;
  endtask

  task automatic expect_rec(input int ch);
    rec_t e;
    e.chan = 5'(ch);
    e.cnt  = cnt_mem[ch];
    e.corr = {high_mem[ch], low_mem[ch]};
    exp_q.push_back(e);
  endtask

  task automatic drain(input string tag);
    int b;
    b = 3000;
    while ((exp_q.size() != 0 || seen != '0) && b > 0) begin
      tick();
      b--;
    end
    check({tag, "_drain_timeout"}, 128'(b == 0), 128'(0));
    repeat (10) tick();
    check({tag, "_no_extra_record"}, 128'(res_valid), 128'(0));
  endtask

  function automatic logic [31:0] reg_addr(input int ch, input int off);
    return BASE + 32'(ch) * STRIDE + 32'(off);
  endfunction

  initial begin
    rst = 1'b1; host_busy = 1'b0; res_ready = 1'b1; seen = '0;
    for (int i = 0; i < NCORR; i++) set_data(i);
    @(posedge clk);
    #1;
    repeat (3) tick();
    check("reset_read", 128'(read), 128'(0));
    check("reset_addr", 128'(addr), 128'(0));
    check("reset_res_valid", 128'(res_valid), 128'(0));
    check("reset_overrun", 128'(overrun), 128'(0));
    rst = 1'b0;
    repeat (2) tick();

    // Single channel, exact bus timing and latency.
    set_data(3);
    expect_rec(3);
    seen[3] = 1'b1;
    tick();
    check("t1_idle_after_rise", 128'(read), 128'(0));
    for (int j = 0; j < 4; j++) begin
      tick();
      check("t1_read", 128'(read), 128'(1));
      check("t1_addr", 128'(addr), 128'(reg_addr(3, 4 * j)));
    end
    tick();
    check("t1_push_no_read", 128'(read), 128'(0));
    check("t1_not_yet_valid", 128'(res_valid), 128'(0));
    tick();
    check("t1_valid", 128'(res_valid), 128'(1));
    check("t1_chan", 128'(res_chan), 128'(3));
    drain("t1");

    // Round-robin from rr=4: 5, 31, 0; then 1 before 0 shows rr ended at 1.
    set_data(0); set_data(5); set_data(31);
    expect_rec(5); expect_rec(31); expect_rec(0);
    seen[0] = 1'b1; seen[5] = 1'b1; seen[31] = 1'b1;
    drain("t2");
    set_data(0); set_data(1);
    expect_rec(1); expect_rec(0);
    seen[0] = 1'b1; seen[1] = 1'b1;
    drain("t2_rr");

    // Host stall of 3 cycles during RD_LOW.
    set_data(9);
    expect_rec(9);
    seen[9] = 1'b1;
    tick();
    tick();
    check("t3_cnt_addr", 128'(addr), 128'(reg_addr(9, 0)));
    tick();
    host_busy = 1'b1;
    #1;
    check("t3_busy_read", 128'(read), 128'(0));
    check("t3_busy_addr", 128'(addr), 128'(0));
    repeat (3) tick();
    check("t3_still_busy_read", 128'(read), 128'(0));
    host_busy = 1'b0;
    #1;
    check("t3_low_retry_read", 128'(read), 128'(1));
    check("t3_low_retry_addr", 128'(addr), 128'(reg_addr(9, 4)));
    tick();
    check("t3_high_addr", 128'(addr), 128'(reg_addr(9, 8)));
    repeat (2) tick();
    check("t3_not_yet_valid", 128'(res_valid), 128'(0));
    tick();
    check("t3_valid", 128'(res_valid), 128'(1));
    drain("t3");

    // FIFO full back-pressure: six flagged, four queued, then ordered drain.
    res_ready = 1'b0;
    for (int c = 10; c <= 20; c += 2) begin
      set_data(c);
      expect_rec(c);
      seen[c] = 1'b1;
    end
    repeat (60) tick();
    check("t4_valid_when_full", 128'(res_valid), 128'(1));
    check("t4_head_chan", 128'(res_chan), 128'(10));
    check("t4_fsm_idle", 128'(read), 128'(0));
    check("t4_unharvested", 128'(seen), 128'(32'h0014_0000));
    res_ready = 1'b1;
    drain("t4");
    check("t4_overrun", 128'(overrun), 128'(0));

    // Second edge on a pending, not-yet-granted channel.
    set_data(1); set_data(2);
    expect_rec(1); expect_rec(2);
    seen[1] = 1'b1;
    tick();
    tick();
    seen[2] = 1'b1;
    tick();
    seen[2] = 1'b0;
    tick();
    seen[2] = 1'b1;
    tick();
    check("t5_overrun_set", 128'(overrun), 128'(32'h0000_0004));
    drain("t5");
    check("t5_overrun_sticky", 128'(overrun), 128'(32'h0000_0004));

    // Reset in RD_HIGH: abort, then re-harvest from the still-set flag.
    set_data(7);
    expect_rec(7);
    seen[7] = 1'b1;
    repeat (4) tick();
    check("t6_in_high", 128'(addr), 128'(reg_addr(7, 8)));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("t6_rst_read", 128'(read), 128'(0));
    check("t6_rst_valid", 128'(res_valid), 128'(0));
    check("t6_rst_overrun", 128'(overrun), 128'(0));
    repeat (2) tick();
    check("t6_restart_addr", 128'(addr), 128'(reg_addr(7, 0)));
    drain("t6");

    // Random rounds: simultaneous flags, random host stalls and back-pressure.
    rr_m = 8;
    for (int rnd = 0; rnd < 30; rnd++) begin
      mask = $urandom & $urandom;
      if (mask == '0) mask = 32'h1 << $urandom_range(31, 0);
      last = 0;
      for (int j = 0; j < NCORR; j++) begin
        if (mask[(rr_m + j) % NCORR]) begin
          set_data((rr_m + j) % NCORR);
          expect_rec((rr_m + j) % NCORR);
          last = (rr_m + j) % NCORR;
        end
      end
      rr_m = (last + 1) % NCORR;
      seen = mask;
      budget = 3000;
      while ((exp_q.size() != 0 || seen != '0) && budget > 0) begin
        host_busy = ($urandom_range(3, 0) == 0);
        res_ready = ($urandom_range(2, 0) != 0);
        tick();
        budget--;
      end
      check("rand_drain_timeout", 128'(budget == 0), 128'(0));
      host_busy = 1'b0;
      res_ready = 1'b1;
    end
    repeat (10) tick();
    check("rand_no_extra_record", 128'(res_valid), 128'(0));
    check("rand_overrun", 128'(overrun), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
